poly_feeder: RTL and testbench
==============================

Name: poly_feeder

Overview:
- Upstream sequencer for the polynomial engine part2, which computes A*x^2 + B*x + C.
- Accepts operands A, B, C, X one at a time over a valid/ready stream.
- Replays each operand onto the engine's DataIn/Go load handshake with programmable Go high and low times.
- Waits out the engine's fixed compute latency, captures DataResult and presents it as a one-cycle-valid result, with the value held until the next capture.

Parameters:
- W, 8: operand/result width; must match the engine.
- GO_HI, 2: cycles Go is held high per operand; minimum 1, a value of 0 is treated as 1.
- GO_LO, 2: cycles Go is held low after operands A, B, C; minimum 1, a value of 0 is treated as 1.
- RES_LAT, 6: cycles from the first Go-low cycle after X until engine DataResult is valid.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset; also drives the engine's Resetn
- in_valid  in  1  operand valid
- in_ready  out  1  feeder can accept an operand
- in_data  in  W  operand, in order A, B, C, X
- poly_go  out  1  to engine Go
- poly_data  out  W  to engine DataIn
- poly_result  in  W  from engine DataResult
- res_valid  out  1  one-cycle pulse: res_data is new
- res_data  out  W  captured result, held
- op_idx  out  2  index of the next/current operand (0=A .. 3=X)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sync, resetn=0): state=IDLE; op_idx=0; poly_go=0; poly_data=0; res_valid=0; res_data=0; all counters=0. Reset mid-sequence abandons the sequence; the engine is reset on the same edge.
- States: IDLE, GO_HI, GO_LO, WAIT_RES, CAPTURE.
- IDLE:
  - in_ready=1, combinational from state only.
  - On an edge with in_valid=1: poly_data<=in_data, poly_go<=1, cnt<=0, go to GO_HI. Go rises the cycle after acceptance.
  - in_valid while not in IDLE is ignored; in_ready=0 in all other states.
- GO_HI:
  - poly_go=1 and poly_data is held.
  - After GO_HI cycles: poly_go<=0, cnt<=0.
  - If op_idx<3, go to GO_LO; if op_idx==3, go to WAIT_RES.
- GO_LO: poly_go=0. After GO_LO cycles: op_idx<=op_idx+1, go to IDLE.
- WAIT_RES:
  - poly_go=0; poly_data is held, with no further drive changes.
  - Counts from 0 on the first Go-low cycle (t0).
  - On the edge ending cycle t0+RES_LAT: res_data<=poly_result, go to CAPTURE.
- CAPTURE: res_valid=1 for exactly one cycle; op_idx<=0; next state IDLE.
- Default timing: A..C each occupy 1 (accept) + GO_HI + GO_LO cycles. Engine sequence after X: X_WAIT sees Go low at t0, CYCLE_0..4 run during t0+1..t0+5, DataResult is updated at the end of t0+5 and sampled at t0+6.
- Go never rises during WAIT_RES or CAPTURE, so the engine is back in LOAD_A before the next A is presented.
- Arithmetic: no arithmetic in the feeder. res_data is exactly the engine's W-bit modulo-2^W result.
- Counters are sized to cover max(GO_HI, GO_LO, RES_LAT) and saturate or clear on each state entry; they never wrap within a state.
- res_data is held across subsequent sequences until the next CAPTURE.

Decomposition:
- Shared package poly_pkg holds:
  - the state enum (IDLE, GO_HI, GO_LO, WAIT_RES, CAPTURE);
  - the operand index constants (OP_A=0, OP_B=1, OP_C=2, OP_X=3);
  - the default engine latency constant ENGINE_RES_LAT=6.
- One natural sub-module: poly_feed_timer, a loadable down-counter with a done flag, reused for the GO_HI, GO_LO and RES_LAT intervals.
- Bench top instantiates poly_feeder driving part2.

Test Plan:
- Basic: A=1, B=2, C=3, X=2 with in_valid always high → res_valid pulses once; res_data=0x0B (4+4+3); busy then drops and in_ready=1.
- Wrap-around: A=16, B=1, C=5, X=16 → res_data=0x15 (A*x^2 wraps to 0, then 16+5).
- Back-to-back sequences: {1,2,3,2} then {2,0,0,3} → res_data 0x0B then 0x12. res_data holds 0x0B between the two pulses; Go stays low during WAIT_RES.
- Handshake stalls: in_valid toggled randomly, and in_data changed while in_ready=0 → ignored data never reaches poly_data; result is still 0x0B for {1,2,3,2}.
- Reset mid-operation: assert resetn=0 during GO_HI of C → next cycle poly_go=0, op_idx=0, res_valid=0, res_data=0. A fresh {3,0,1,1} afterwards gives res_data=0x04.
- Parameter corners: GO_HI=1, GO_LO=1; then GO_HI=4, GO_LO=3 → the same results as the Basic test, Go high widths measured exactly 1 and 4 cycles, and res_valid exactly RES_LAT+1 cycles after Go falls for X.

Source files
------------

// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
// poly_pkg : shared types and constants for the poly_feeder slice
// Rev 1.0  : initial release
// ============================================================================
package poly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GO_HI    = 3'd1,
        ST_GO_LO    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_CAPTURE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_X = 2'd3;

    localparam int ENGINE_RES_LAT = 6;

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_feeder_if.sv
`default_nettype none
// ============================================================================
// poly_feeder_if : operand stream in, captured result out
// Rev 1.0        : initial release
// ============================================================================
interface poly_feeder_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         res_valid;
    logic [W-1:0] res_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output res_valid,
        output res_data
    );
endinterface
`default_nettype wire

// File: rtl/poly_feed_timer.sv
`default_nettype none
// ============================================================================
// poly_feed_timer : loadable down-counter, done while the count is zero
// Rev 1.0         : initial release
// ============================================================================
module poly_feed_timer #(
    parameter int CW = 3
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          load,
    input  wire logic [CW-1:0] load_val,
    output logic               done
);
    logic [CW-1:0] r_cnt;

    // Holds at zero once expired, so it never wraps while a state lingers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/poly_feeder.sv
`default_nettype none
// ============================================================================
// poly_feeder : replays A, B, C, X onto the engine Go/DataIn handshake and
//               captures DataResult after the engine's compute latency
// Rev 1.0     : initial release
// ============================================================================
module poly_feeder
    import poly_pkg::*;
#(
    parameter int W       = 8,
    parameter int GO_HI   = 2,
    parameter int GO_LO   = 2,
    parameter int RES_LAT = ENGINE_RES_LAT
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    poly_feeder_if.slave      bus,
    output logic              poly_go,
    output logic [W-1:0]      poly_data,
    input  wire logic [W-1:0] poly_result,
    output logic [1:0]        op_idx,
    output logic              busy
);
    localparam int HI_N = at_least_one(GO_HI);
    localparam int LO_N = at_least_one(GO_LO);
    localparam int MAXV = max3(HI_N, LO_N, at_least_one(RES_LAT));
    localparam int CW   = $clog2(MAXV + 1);

    // An N-cycle interval loads N-1: the first cycle in the state sees N-1.
    localparam logic [CW-1:0] HI_LOAD  = CW'(HI_N - 1);
    localparam logic [CW-1:0] LO_LOAD  = CW'(LO_N - 1);
    localparam logic [CW-1:0] RES_LOAD = CW'(RES_LAT);

    state_t         r_state;
    logic [1:0]     r_op_idx;
    logic           r_go;
    logic [W-1:0]   r_data;
    logic           r_res_valid;
    logic [W-1:0]   r_res_data;

    logic           w_load;
    logic [CW-1:0]  w_load_val;
    logic           w_done;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_load     = 1'b1;
                    w_load_val = HI_LOAD;
                end
            end
            ST_GO_HI: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = (r_op_idx == OP_X) ? RES_LOAD : LO_LOAD;
                end
            end
            default: ;
        endcase
    end

    poly_feed_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_op_idx    <= OP_A;
            r_go        <= 1'b0;
            r_data      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_data  <= bus.in_data;
                        r_go    <= 1'b1;
                        r_state <= ST_GO_HI;
                    end
                end
                ST_GO_HI: begin
                    if (w_done) begin
                        r_go    <= 1'b0;
                        r_state <= (r_op_idx == OP_X) ? ST_WAIT_RES : ST_GO_LO;
                    end
                end
                ST_GO_LO: begin
                    if (w_done) begin
                        r_op_idx <= r_op_idx + 2'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WAIT_RES: begin
                    if (w_done) begin
                        r_res_data  <= poly_result;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_op_idx <= OP_A;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign poly_go       = r_go;
    assign poly_data     = r_data;
    assign op_idx        = r_op_idx;
    assign busy          = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_poly_feeder.sv
`default_nettype none
// ============================================================================
// tb_poly_feeder : three feeders with different Go timings, each driving a
//                  behavioural model of the polynomial engine
// Rev 1.0        : initial release
// ============================================================================
module tb_poly_feeder;
    import poly_pkg::*;

    localparam int NI = 3;
    localparam int RL = ENGINE_RES_LAT;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       stim_valid = 1'b0;
    logic [7:0] stim_data  = 8'd0;
    logic       mon_clr    = 1'b0;
    int         sel        = 0;

    logic        rdy [NI];
    logic        rv  [NI];
    logic [7:0]  rd  [NI];
    logic        go  [NI];
    logic [7:0]  pd  [NI];
    logic [1:0]  oi  [NI];
    logic        bsy [NI];
    int          m_wmin [NI];
    int          m_wmax [NI];
    int          m_rv   [NI];
    int          m_dly  [NI];
    int          m_gow  [NI];
    logic [31:0] m_ops  [NI];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] lres [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int GH = (k == 0) ? 2 : (k == 1) ? 1 : 4;
        localparam int GL = (k == 0) ? 2 : (k == 1) ? 1 : 3;

        poly_feeder_if #(.W(8)) bus ();
        logic       go_k;
        logic [7:0] pdata_k;
        logic [7:0] result_k;
        logic [1:0] opi_k;
        logic       busy_k;

        assign bus.in_valid = (sel == k) ? stim_valid : 1'b0;
        assign bus.in_data  = stim_data;

        poly_feeder #(.W(8), .GO_HI(GH), .GO_LO(GL), .RES_LAT(RL)) dut (
            .clk         (clk),
            .resetn      (resetn),
            .bus         (bus),
            .poly_go     (go_k),
            .poly_data   (pdata_k),
            .poly_result (result_k),
            .op_idx      (opi_k),
            .busy        (busy_k)
        );

        // Engine: latches an operand per Go pulse; after X, result appears
        // at the end of the fifth cycle following the first Go-low cycle.
        logic       go_q = 1'b0;
        logic [7:0] ops [4];
        int n = 0, t = 0, cyc = 0, run = 0, t0c = 0;
        int wmin = 1000, wmax = 0, rvc = 0, dly = -1, gow = 0;
        bit in_wait = 1'b0;

        always @(posedge clk) begin
            cyc  <= cyc + 1;
            go_q <= go_k;
            if (!resetn) begin
                n <= 0;
                t <= 0;
            end else begin
                if (go_k && !go_q && n < 4) begin
                    ops[n] <= pdata_k;
                    n      <= n + 1;
                    if (n == 0) result_k <= 8'($urandom);
                end
                if (!go_k && go_q && n == 4) begin
                    t <= 1;
                end else if (t == 5) begin
                    result_k <= 8'(ops[0] * ops[3] * ops[3] + ops[1] * ops[3] + ops[2]);
                    t <= 0;
                    n <= 0;
                end else if (t > 0) begin
                    t <= t + 1;
                end
            end

            if (mon_clr) begin
                wmin <= 1000; wmax <= 0; rvc <= 0; dly <= -1; gow <= 0;
                run <= 0; in_wait <= 1'b0;
            end else begin
                if (go_k) begin
                    run <= run + 1;
                end else if (run > 0) begin
                    run <= 0;
                    if (run < wmin) wmin <= run;
                    if (run > wmax) wmax <= run;
                end
                if (go_q && !go_k) begin
                    t0c <= cyc;
                    if (opi_k == 2'd3) in_wait <= 1'b1;
                end
                if (in_wait && go_k) gow <= gow + 1;
                if (bus.res_valid) begin
                    rvc     <= rvc + 1;
                    dly     <= cyc - t0c;
                    in_wait <= 1'b0;
                end
            end
        end

        assign rdy[k]    = bus.in_ready;
        assign rv[k]     = bus.res_valid;
        assign rd[k]     = bus.res_data;
        assign go[k]     = go_k;
        assign pd[k]     = pdata_k;
        assign oi[k]     = opi_k;
        assign bsy[k]    = busy_k;
        assign m_wmin[k] = wmin;
        assign m_wmax[k] = wmax;
        assign m_rv[k]   = rvc;
        assign m_dly[k]  = dly;
        assign m_gow[k]  = gow;
        assign m_ops[k]  = {ops[3], ops[2], ops[1], ops[0]};
    end

    function automatic int gh(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [7:0] ref_poly(input logic [7:0] a, b, c, x);
        int v;
        v = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
        return 8'(v & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_op(input logic [7:0] v, input bit stall);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            stim_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            stim_data  = (stim_valid && rdy[sel]) ? v : 8'($urandom);
            done       = stim_valid && rdy[sel];
            guard++;
        end
        if (!done) chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_seq(input logic [7:0] a, b, c, x, input bit stall);
        logic [7:0] exp_r;
        bit got;
        exp_r = ref_poly(a, b, c, x);
        @(negedge clk);
        stim_valid = 1'b0;
        mon_clr    = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        send_op(a, stall);
        send_op(b, stall);
        send_op(c, stall);
        send_op(x, stall);
        chk("res_hold", 32'(rd[sel]), 32'(lres[sel]));
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rv[sel]) begin
                got = 1'b1;
            end else begin
                stim_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                stim_data  = 8'($urandom);
            end
        end
        stim_valid = 1'b0;
        chk("res_seen", 32'(got), 32'd1);
        chk("res_data", 32'(rd[sel]), 32'(exp_r));
        chk("busy_capture", 32'(bsy[sel]), 32'd1);
        @(negedge clk);
        chk("eng_operands", m_ops[sel], {x, c, b, a});
        chk("go_hi_min", m_wmin[sel], gh(sel));
        chk("go_hi_max", m_wmax[sel], gh(sel));
        chk("res_delay", m_dly[sel], RL + 1);
        chk("go_in_wait", m_gow[sel], 0);
        chk("res_pulses", m_rv[sel], 1);
        chk("res_valid_low", 32'(rv[sel]), 32'd0);
        chk("busy_after", 32'(bsy[sel]), 32'd0);
        chk("ready_after", 32'(rdy[sel]), 32'd1);
        chk("op_idx_after", 32'(oi[sel]), 32'd0);
        chk("res_held", 32'(rd[sel]), 32'(exp_r));
        lres[sel] = exp_r;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) lres[i] = 8'd0;
        sel    = 0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(go[0]), 32'd0);
        chk("rst_data", 32'(pd[0]), 32'd0);
        chk("rst_op_idx", 32'(oi[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_res_valid", 32'(rv[0]), 32'd0);
        chk("rst_res_data", 32'(rd[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        resetn = 1'b1;

        run_seq(8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        run_seq(8'd16, 8'd1, 8'd5, 8'd16, 1'b0);
        run_seq(8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        run_seq(8'd2, 8'd0, 8'd0, 8'd3, 1'b0);
        run_seq(8'd1, 8'd2, 8'd3, 8'd2, 1'b1);

        // Abandon a sequence during the Go-high phase of C.
        @(negedge clk);
        send_op(8'd9, 1'b0);
        send_op(8'd8, 1'b0);
        send_op(8'd7, 1'b0);
        @(negedge clk);
        chk("go_before_reset", 32'(go[0]), 32'd1);
        chk("op_idx_c", 32'(oi[0]), 32'd2);
        stim_valid = 1'b0;
        resetn     = 1'b0;
        @(negedge clk);
        chk("mid_rst_go", 32'(go[0]), 32'd0);
        chk("mid_rst_op_idx", 32'(oi[0]), 32'd0);
        chk("mid_rst_res_valid", 32'(rv[0]), 32'd0);
        chk("mid_rst_res_data", 32'(rd[0]), 32'd0);
        chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < NI; i++) lres[i] = 8'd0;
        run_seq(8'd3, 8'd0, 8'd1, 8'd1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end

        sel = 1;
        run_seq(8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        sel = 2;
        run_seq(8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
